// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg: shared state, instruction-type, condition and mux encodings for the control unit
package mc_ctrl_pkg;
  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR, S_BRANCH, S_HALT
  } state_t;
  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cc_t;
  localparam logic [2:0] IT_DP_REG = 3'b000;
  localparam logic [2:0] IT_DP_IMM = 3'b001;
  localparam logic [2:0] IT_MEM    = 3'b010;
  localparam logic [2:0] IT_BR     = 3'b011;
  localparam logic [2:0] IT_BRL    = 3'b100;
  localparam logic [2:0] IT_HALT   = 3'b111;
  localparam logic [1:0] DREG_ALU  = 2'b00;
  localparam logic [1:0] DREG_MDR  = 2'b01;
  localparam logic [1:0] DREG_PC   = 2'b10;
  localparam logic [1:0] SRCB_REG  = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [2:0] ALU_ADD   = 3'b000;
endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: IR/flag inputs and datapath control outputs of the multicycle control unit
interface mc_ctrl_if #(parameter int OPC_W = 3, parameter int ALUOP_W = 3);
  logic [2:0]         it;
  logic [OPC_W-1:0]   opc;
  logic [3:0]         cc;
  logic               z, n, c, v, ld, mem_ready;
  logic               cond;
  logic [ALUOP_W-1:0] aluoperation;
  logic               pcsrc, pcwrite, mems, memread, memwrite, loadir, reg2, wreg;
  logic [1:0]         dreg;
  logic               regwrite, srca;
  logic [1:0]         srcb;
  logic               loadf, halted;
  modport master (
    input  it, opc, cc, z, n, c, v, ld, mem_ready,
    output cond, aluoperation, pcsrc, pcwrite, mems, memread, memwrite, loadir,
           reg2, wreg, dreg, regwrite, srca, srcb, loadf, halted
  );
  modport slave (
    output it, opc, cc, z, n, c, v, ld, mem_ready,
    input  cond, aluoperation, pcsrc, pcwrite, mems, memread, memwrite, loadir,
           reg2, wreg, dreg, regwrite, srca, srcb, loadf, halted
  );
endinterface

// File: rtl/mc_control_unit_cond.sv
// mc_cond_eval: combinational 16-code condition check against z/n/c/v flags
module mc_cond_eval
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] i_cc,
  input  logic       i_z, i_n, i_c, i_v,
  output logic       o_cond
);
  always_comb begin
    o_cond = 1'b0;
    case (cc_t'(i_cc))
      CC_EQ: o_cond = i_z;
      CC_NE: o_cond = !i_z;
      CC_CS: o_cond = i_c;
      CC_CC: o_cond = !i_c;
      CC_MI: o_cond = i_n;
      CC_PL: o_cond = !i_n;
      CC_VS: o_cond = i_v;
      CC_VC: o_cond = !i_v;
      CC_HI: o_cond = i_c && !i_z;
      CC_LS: o_cond = !i_c || i_z;
      CC_GE: o_cond = i_n == i_v;
      CC_LT: o_cond = i_n != i_v;
      CC_GT: o_cond = !i_z && (i_n == i_v);
      CC_LE: o_cond = i_z || (i_n != i_v);
      CC_AL: o_cond = 1'b1;
      CC_NV: o_cond = 1'b0;
      default: o_cond = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle instruction-sequencing FSM with ALU-op decode and condition evaluation
module mc_control_unit
  import mc_ctrl_pkg::*;
#(
  parameter int                 OPC_W   = 3,
  parameter int                 ALUOP_W = 3,
  parameter logic [ALUOP_W-1:0] ALU_ADD = '0,
  parameter logic [OPC_W-1:0]   CMP_OPC = OPC_W'(3'b110),
  parameter bit                 WAIT_EN = 1'b1
) (
  input logic       clk,
  input logic       rst,
  mc_ctrl_if.master bus
);
  state_t r_state, w_next;
  logic   w_rdy, w_cond;
  assign w_rdy    = WAIT_EN ? bus.mem_ready : 1'b1;
  assign bus.cond = w_cond;
  mc_cond_eval u_cond (
    .i_cc(bus.cc), .i_z(bus.z), .i_n(bus.n), .i_c(bus.c), .i_v(bus.v), .o_cond(w_cond)
  );
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= S_FETCH;
    else r_state <= w_next;
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH:    w_next = w_rdy ? S_DECODE : S_FETCH;
      S_DECODE:   w_next = !w_cond ? S_FETCH :
                           (bus.it == IT_DP_REG || bus.it == IT_DP_IMM) ? S_EXEC :
                           bus.it == IT_MEM ? S_MEM_ADDR :
                           (bus.it == IT_BR || bus.it == IT_BRL) ? S_BRANCH :
                           bus.it == IT_HALT ? S_HALT : S_FETCH;
      S_EXEC:     w_next = S_FETCH;
      S_MEM_ADDR: w_next = bus.ld ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   w_next = w_rdy ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   w_next = S_FETCH;
      S_MEM_WR:   w_next = w_rdy ? S_FETCH : S_MEM_WR;
      S_BRANCH:   w_next = S_FETCH;
      S_HALT:     w_next = S_HALT;
      default:    w_next = S_FETCH;
    endcase
  end
  // rst gates every strobe so a pending access is dropped in the same cycle
  always_comb begin
    bus.aluoperation = '0;
    bus.pcsrc        = 1'b0;
    bus.pcwrite      = 1'b0;
    bus.mems         = 1'b0;
    bus.memread      = 1'b0;
    bus.memwrite     = 1'b0;
    bus.loadir       = 1'b0;
    bus.reg2         = 1'b0;
    bus.wreg         = 1'b0;
    bus.dreg         = DREG_ALU;
    bus.regwrite     = 1'b0;
    bus.srca         = 1'b0;
    bus.srcb         = SRCB_REG;
    bus.loadf        = 1'b0;
    bus.halted       = 1'b0;
    if (!rst)
      case (r_state)
        S_FETCH: begin
          bus.memread      = 1'b1;
          bus.srcb         = SRCB_ONE;
          bus.aluoperation = ALU_ADD;
          bus.loadir       = w_rdy;
          bus.pcwrite      = w_rdy;
        end
        S_DECODE: bus.reg2 = bus.it == IT_MEM && !bus.ld;
        S_EXEC: begin
          bus.srca         = 1'b1;
          bus.srcb         = bus.it == IT_DP_IMM ? SRCB_IMM : SRCB_REG;
          bus.aluoperation = ALUOP_W'(bus.opc);
          bus.loadf        = 1'b1;
          bus.regwrite     = bus.opc != CMP_OPC;
        end
        S_MEM_ADDR: begin
          bus.srca         = 1'b1;
          bus.srcb         = SRCB_IMM;
          bus.aluoperation = ALU_ADD;
          bus.reg2         = !bus.ld;
        end
        S_MEM_RD: begin
          bus.mems    = 1'b1;
          bus.memread = 1'b1;
        end
        S_MEM_WB: begin
          bus.regwrite = 1'b1;
          bus.dreg     = DREG_MDR;
        end
        S_MEM_WR: begin
          bus.mems     = 1'b1;
          bus.reg2     = 1'b1;
          bus.memwrite = 1'b1;
        end
        S_BRANCH: begin
          bus.pcsrc    = 1'b1;
          bus.pcwrite  = 1'b1;
          bus.regwrite = bus.it == IT_BRL;
          bus.wreg     = bus.it == IT_BRL;
          bus.dreg     = bus.it == IT_BRL ? DREG_PC : DREG_ALU;
        end
        S_HALT: bus.halted = 1'b1;
        default: bus.halted = 1'b0;
      endcase
  end
endmodule
